forward_select_unit: RTL and testbench

FORWARD_SELECT_UNIT -- requirements
Module: forward_select_unit

---
 rtl/forward_select_unit.sv | 120 ++++++++++++
 tb/tb_forward_select_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/forward_select_unit.sv
// Forwarding-select and load-use stall unit for a 5-stage pipeline.
// Shadows the EX/MEM/WB(/RET) destination info and produces registered
// operand-mux selects for the instruction entering EX, plus a combinational
// load-use stall.
// Optional feature: define FWD_RET_STAGE_EN to track a RET stage and emit
// select code 3 for WB-stage producers; otherwise WB producers select the
// register file (write-first RF).
module forward_select_unit (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       ID_Valid,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic [4:0] ID_Rd,
    input  logic       ID_RegWrite,
    input  logic       ID_MemRead,
    input  logic       Hold,
    input  logic       Flush,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB,
    output logic       Stall
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       regwrite;
        logic       memread;
    } stage_t;

    typedef enum logic {StRun, StStall} state_e;

    state_e     state_q, state_d;
    stage_t     ex_q, mem_q, wb_q;
    stage_t     ex_d;
    logic [1:0] fwd_a_d, fwd_b_d;
    logic       load_use, issue;
    logic       ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;

`ifdef FWD_RET_STAGE_EN
    stage_t ret_q;
    logic   unused_bits;
    // RET is shadowed for completeness; nothing downstream matches against it.
    assign unused_bits = ^{ret_q, mem_q.memread};
`else
    logic   unused_bits;
    // Without RET, WB producers resolve through the write-first register file.
    assign unused_bits = ^{wb_q, mem_q.memread, wb_a, wb_b};
`endif

    // Producer matches of the decode sources against the current stages.
    always_comb begin
        ex_a  = ex_q.valid  && ex_q.regwrite  && (ex_q.dest  == ID_Rs) && (ID_Rs != 5'd0);
        ex_b  = ex_q.valid  && ex_q.regwrite  && (ex_q.dest  == ID_Rt) && (ID_Rt != 5'd0);
        mem_a = mem_q.valid && mem_q.regwrite && (mem_q.dest == ID_Rs) && (ID_Rs != 5'd0);
        mem_b = mem_q.valid && mem_q.regwrite && (mem_q.dest == ID_Rt) && (ID_Rt != 5'd0);
        wb_a  = wb_q.valid  && wb_q.regwrite  && (wb_q.dest  == ID_Rs) && (ID_Rs != 5'd0);
        wb_b  = wb_q.valid  && wb_q.regwrite  && (wb_q.dest  == ID_Rt) && (ID_Rt != 5'd0);
    end

    // Load-use detection, stall, FSM next state and EX/select next values.
    always_comb begin
        load_use = ex_q.valid && ex_q.memread && ex_q.regwrite && (ex_q.dest != 5'd0) &&
                   ((ex_q.dest == ID_Rs) || (ex_q.dest == ID_Rt));
        Stall    = (state_q == StRun) && ID_Valid && !Flush && load_use;
        issue    = ID_Valid && !Flush && !Stall;

        state_d = state_q;
        unique case (state_q)
            StRun:   if (Stall) state_d = StStall;
            StStall: state_d = StRun;
            default: state_d = StRun;
        endcase

        ex_d    = '0;
        fwd_a_d = 2'd0;
        fwd_b_d = 2'd0;
        if (issue) begin
            ex_d = '{valid: 1'b1, dest: ID_Rd, regwrite: ID_RegWrite, memread: ID_MemRead};
            // Lookahead: a stage's producer will sit one stage further on next cycle,
            // so EX match -> MEM result (1), MEM match -> WB result (2), WB -> RET (3).
            if (ex_a)       fwd_a_d = 2'd1;
            else if (mem_a) fwd_a_d = 2'd2;
`ifdef FWD_RET_STAGE_EN
            else if (wb_a)  fwd_a_d = 2'd3;
`endif
            if (ex_b)       fwd_b_d = 2'd1;
            else if (mem_b) fwd_b_d = 2'd2;
`ifdef FWD_RET_STAGE_EN
            else if (wb_b)  fwd_b_d = 2'd3;
`endif
        end
    end

    // Stage shadows, FSM and registered selects; reset beats Hold, Hold freezes all.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= StRun;
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
`ifdef FWD_RET_STAGE_EN
            ret_q    <= '0;
`endif
            ForwardA <= 2'd0;
            ForwardB <= 2'd0;
        end else if (!Hold) begin
            state_q  <= state_d;
`ifdef FWD_RET_STAGE_EN
            ret_q    <= wb_q;
`endif
            wb_q     <= mem_q;
            mem_q    <= ex_q;
            ex_q     <= ex_d;
            ForwardA <= fwd_a_d;
            ForwardB <= fwd_b_d;
        end
    end

endmodule

// File: tb/tb_forward_select_unit.sv
// Self-checking bench for forward_select_unit: directed scenarios followed by
// random traffic, all compared against a history-based reference model.
module tb_forward_select_unit;

    logic       clk = 1'b0;
    logic       rst_n, id_valid, id_regwrite, id_memread, hold, flush;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [1:0] fwd_a, fwd_b;
    logic       stall;

    int n_assert = 0;
    int n_fail   = 0;

    forward_select_unit dut (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .ID_Valid   (id_valid),
        .ID_Rs      (id_rs),
        .ID_Rt      (id_rt),
        .ID_Rd      (id_rd),
        .ID_RegWrite(id_regwrite),
        .ID_MemRead (id_memread),
        .Hold       (hold),
        .Flush      (flush),
        .ForwardA   (fwd_a),
        .ForwardB   (fwd_b),
        .Stall      (stall)
    );

    always #5 clk = ~clk;

    // Reference model: the last three instructions issued into EX, youngest first.
    typedef struct {
        bit       v;
        bit [4:0] d;
        bit       rw;
        bit       mr;
    } ent_t;

    ent_t     hist[3];
    bit [1:0] exp_a, exp_b;
    bit       exp_stall;
    logic     stall_seen;

`ifdef FWD_RET_STAGE_EN
    localparam int Reach = 3;
`else
    localparam int Reach = 2;
`endif

    function automatic bit writes(ent_t e, bit [4:0] r);
        return e.v && e.rw && (e.d == r) && (r != 0);
    endfunction

    // Code = how many cycles ago the youngest producer issued; beyond reach -> RF.
    function automatic bit [1:0] pick(bit [4:0] r);
        for (int i = 0; i < Reach; i++)
            if (writes(hist[i], r)) return 2'(i + 1);
        return 2'd0;
    endfunction

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit [4:0] rs, input bit [4:0] rt,
                        input bit [4:0] rd, input bit rw, input bit mr,
                        input bit hld, input bit fl);
        @(negedge clk);
        rst_n = !rst; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_regwrite = rw; id_memread = mr; hold = hld; flush = fl;
        #1;
        exp_stall = v && !fl && hist[0].v && hist[0].mr && writes(hist[0], hist[0].d) &&
                    (hist[0].d == rs || hist[0].d == rt);
        stall_seen = stall;
        check("stall", {1'b0, stall}, {1'b0, exp_stall});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};
            exp_a = 0; exp_b = 0;
        end else if (!hld) begin
            bit issue;
            issue = v && !fl && !exp_stall;
            exp_a = issue ? pick(rs) : 2'd0;
            exp_b = issue ? pick(rt) : 2'd0;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = issue ? '{1, rd, rw, mr} : '{0, 0, 0, 0};
        end
        #1;
        check("fwd_a", fwd_a, exp_a);
        check("fwd_b", fwd_b, exp_b);
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};
        exp_a = 0; exp_b = 0;
        rst_n = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_regwrite = 0; id_memread = 0; hold = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_fa", fwd_a, 2'd0);
        check("reset_fb", fwd_b, 2'd0);
        check("reset_stall", {1'b0, stall}, 2'd0);

        // add $3 ; add $4,$3,$1 back to back
        step(0, 1, 0, 0, 3, 1, 0, 0, 0);
        step(0, 1, 3, 1, 4, 1, 0, 0, 0);
        check("b2b_fa", fwd_a, 2'd1);
        check("b2b_nostall", {1'b0, stall_seen}, 2'd0);
        nop(); nop(); nop();

        // lw $5 ; add $6,$5,$5 -> one stall cycle, then WB forward
        step(0, 1, 0, 0, 5, 1, 1, 0, 0);
        step(0, 1, 5, 5, 6, 1, 0, 0, 0);
        check("lu_stall", {1'b0, stall_seen}, 2'd1);
        check("lu_bubble_fa", fwd_a, 2'd0);
        step(0, 1, 5, 5, 6, 1, 0, 0, 0);
        check("lu_once", {1'b0, stall_seen}, 2'd0);
        check("lu_fa", fwd_a, 2'd2);
        check("lu_fb", fwd_b, 2'd2);
        nop(); nop(); nop();

        // add $7 ; nop ; nop ; sub $8,$2,$7
        step(0, 1, 0, 0, 7, 1, 0, 0, 0);
        nop(); nop();
        step(0, 1, 2, 7, 8, 1, 0, 0, 0);
`ifdef FWD_RET_STAGE_EN
        check("ret_fb", fwd_b, 2'd3);
`else
        check("ret_fb", fwd_b, 2'd0);
`endif
        nop(); nop(); nop();

        // Two producers of $9: youngest wins; then the same with $0
        step(0, 1, 0, 0, 9, 1, 0, 0, 0);
        step(0, 1, 0, 0, 9, 1, 0, 0, 0);
        step(0, 1, 9, 0, 10, 1, 0, 0, 0);
        check("young_fa", fwd_a, 2'd1);
        step(0, 1, 0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 11, 1, 0, 0, 0);
        check("r0_fa", fwd_a, 2'd0);
        nop(); nop(); nop();

        // Flush overrides load-use
        step(0, 1, 0, 0, 5, 1, 1, 0, 0);
        step(0, 1, 5, 0, 6, 1, 0, 0, 1);
        check("flush_nostall", {1'b0, stall_seen}, 2'd0);
        check("flush_fa", fwd_a, 2'd0);
        nop(); nop(); nop();

        // Reset while stalled
        step(0, 1, 0, 0, 5, 1, 1, 0, 0);
        step(0, 1, 5, 5, 6, 1, 0, 0, 0);
        check("pre_rst_stall", {1'b0, stall_seen}, 2'd1);
        step(1, 1, 5, 5, 6, 1, 0, 1, 1);
        check("rst_fa", fwd_a, 2'd0);
        check("rst_fb", fwd_b, 2'd0);
        step(0, 1, 5, 5, 6, 1, 0, 0, 0);
        check("rst_nostall", {1'b0, stall_seen}, 2'd0);
        nop(); nop(); nop();

        // Hold for three cycles keeps the select
        step(0, 1, 0, 0, 3, 1, 0, 0, 0);
        step(0, 1, 3, 3, 4, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 4, 3, 12, 1, 1, 1, $urandom_range(0, 1) == 1);
            check("hold_fa", fwd_a, 2'd1);
            check("hold_fb", fwd_b, 2'd1);
        end
        nop(); nop(); nop();

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
